// File: rtl/if_fetch.sv
// if_fetch: byte-serial instruction fetch, assembling four little-endian bytes into one word for IF/ID
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global freeze when low)
//   pc_in, branch_flush_in, stall_in[1] (hold IF output)
//   mem_req_out, mem_addr_out, mem_byte_valid_in, mem_byte_in (byte-read memory port)
//   if_stall_req_out, inst_out, inst_pc_out, inst_valid_out (to stall control and IF/ID)
module if_fetch #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] pc_in,
    input  logic        branch_flush_in,
    input  logic [5:0]  stall_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_byte_valid_in,
    input  logic [7:0]  mem_byte_in,
    output logic        if_stall_req_out,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc_out,
    output logic        inst_valid_out
);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] base_q, base_d;
    logic [31:0] data_q, data_d;
    logic        unused_stall;
    assign unused_stall = ^{stall_in[5:2], stall_in[0]};
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            data_q  <= data_d;
        end
    end
    // Flush outranks every state transition, including the 4th byte and a stalled HOLD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        data_d  = data_q;
        if (rdy_in) begin
            if (branch_flush_in) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        base_d  = pc_in;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                    BUSY: if (mem_byte_valid_in) begin
                        data_d[{cnt_q, 3'b000} +: 8] = mem_byte_in;
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) state_d = HOLD;
                    end
                    HOLD: if (!stall_in[1]) state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end
    assign mem_req_out      = state_q == BUSY;
    assign mem_addr_out     = base_q + {30'd0, cnt_q};
    // IDLE always launches a fetch when ready and not flushed, so that cycle already stalls the front end.
    assign if_stall_req_out = (state_q == BUSY) |
                              ((state_q == IDLE) & rst_in & rdy_in & ~branch_flush_in);
    assign inst_valid_out   = state_q == HOLD;
    assign inst_out         = inst_valid_out ? data_q : NOP_INST;
    assign inst_pc_out      = base_q;
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h00000013, the instruction word driven on inst_out when no valid instruction is held.
REQ-002 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port rdy_in, input, 1, global ready; low freezes all state.
REQ-005 SHALL have port pc_in, input, 32, fetch address from the PC register.
REQ-006 SHALL have port branch_flush_in, input, 1, redirect from EX; abandons the current fetch.
REQ-007 SHALL have port stall_in, input, 6, stall vector from stall control; bit 1 holds the IF output.
REQ-008 SHALL have port mem_req_out, output, 1, byte-read request to the memory controller.
REQ-009 SHALL have port mem_addr_out, output, 32, byte address of the current request.
REQ-010 SHALL have port mem_byte_valid_in, input, 1, returned byte is valid this cycle.
REQ-011 SHALL have port mem_byte_in, input, 8, returned byte.
REQ-012 SHALL have port if_stall_req_out, output, 1, stall request to stall control while an instruction is incomplete.
REQ-013 SHALL have port inst_out, output, 32, fetched instruction, little-endian.
REQ-014 SHALL have port inst_pc_out, output, 32, address of inst_out.
REQ-015 SHALL have port inst_valid_out, output, 1, inst_out/inst_pc_out valid for IF/ID.

Function
REQ-016 SHALL implement the FSM states IDLE, BUSY and HOLD, with a 2-bit byte counter cnt and a 32-bit base register.
REQ-017 In IDLE with rdy_in=1 and branch_flush_in=0, the block SHALL latch base<=pc_in, set cnt<=0, assert mem_req_out and go to BUSY.
REQ-018 In BUSY, mem_req_out SHALL be 1 and mem_addr_out SHALL equal base+cnt, a 32-bit add that wraps at 2^32.
REQ-019 In BUSY, each cycle with mem_byte_valid_in=1 SHALL store mem_byte_in into bits [8*cnt+7:8*cnt] and increment cnt.
REQ-020 When the byte with cnt=3 is accepted, the block SHALL go to HOLD and drive inst_valid_out=1, inst_out=the assembled word and inst_pc_out=base on the next cycle; mem_req_out SHALL be 0 from that cycle.
REQ-021 if_stall_req_out SHALL be 1 in BUSY and in the IDLE cycle that launches a fetch, and 0 in HOLD.
REQ-022 In HOLD with stall_in[1]=1, all outputs SHALL be held unchanged.
REQ-023 In HOLD with stall_in[1]=0, the block SHALL clear inst_valid_out and return to IDLE, so one instruction is consumed per HOLD exit.
REQ-024 Latency SHALL be 1 launch cycle plus 4 byte cycles, with inst_valid_out rising on the cycle after the 4th byte, assuming zero-wait memory.
REQ-025 branch_flush_in=1 in any state SHALL force IDLE, cnt<=0, inst_valid_out<=0, inst_out<=NOP_INST and mem_req_out<=0 on the next edge; partially assembled bytes are discarded.
REQ-026 Simultaneous flush and 4th byte: flush SHALL win and no instruction is produced.
REQ-027 Simultaneous flush and HOLD with stall_in[1]=1: flush SHALL win and the held instruction is dropped.
REQ-028 rdy_in=0 SHALL freeze state, cnt, base and all outputs; mem_byte_valid_in SHALL be ignored that cycle.
REQ-029 When inst_valid_out=0, inst_out SHALL equal NOP_INST.

Reset
REQ-030 On rst_in=0, regardless of clock, the block SHALL enter IDLE with cnt=0, base=0, mem_req_out=0, mem_addr_out=0, if_stall_req_out=0, inst_valid_out=0, inst_out=NOP_INST and inst_pc_out=0.
REQ-031 Reset asserted mid-fetch SHALL abort the fetch; after release the first fetch SHALL start from pc_in.

Verification
REQ-032 Normal fetch: pc_in=0x100, bytes 13,05,10,00 on consecutive cycles -> mem_addr_out 0x100..0x103; inst_out=0x00100513, inst_pc_out=0x100, inst_valid_out=1 one cycle after the 4th byte.
REQ-033 Flush mid-fetch: flush after 2 bytes -> mem_req_out=0 next cycle, no inst_valid_out; next fetch starts at new pc_in with cnt=0.
REQ-034 Downstream stall: HOLD with stall_in[1]=1 for 3 cycles -> inst_out/inst_pc_out stable, inst_valid_out=1; release -> IDLE, next fetch launched.
REQ-035 rdy_in low: drop rdy_in for 2 cycles during BUSY with mem_byte_valid_in=1 -> cnt and mem_addr_out unchanged, bytes not stored.
REQ-036 Wrap: pc_in=0xFFFFFFFE -> mem_addr_out sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-037 Async reset: assert rst_in=0 between clock edges during BUSY -> outputs reach reset values immediately, without waiting for an edge.
